// File: rtl/alu_if.sv
// Operand/control and result bundle for the single-cycle ALU.
// master drives operands and controls; slave (the ALU) returns result and flags.
interface alu_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [IMM_W-1:0] imm;
  logic             imm_sel;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, in_a, in_b, imm, imm_sel, alu_op,
    input  result, out_valid, zero, ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, imm, imm_sel, alu_op,
    output result, out_valid, zero, ovf
  );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU with an immediate/register operand-B mux.
// Outputs hold their last values while in_valid is low; only out_valid drops.
module alu #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input logic   clk,
  input logic   reset,
  alu_if.slave  bus
);
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_ORR   = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_TCP   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_LHI   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_valid;

  always_comb begin
    if (bus.imm_sel) w_b = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    else             w_b = bus.in_b;
  end

  assign w_sum  = bus.in_a + w_b;
  assign w_diff = bus.in_a - w_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.in_a[WIDTH-1] == w_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (bus.in_a[WIDTH-1] != w_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_AND:   w_res = bus.in_a & w_b;
      OP_ORR:   w_res = bus.in_a | w_b;
      OP_NOT:   w_res = ~bus.in_a;
      OP_TCP:   w_res = '0 - bus.in_a;
      OP_SHL:   w_res = {bus.in_a[WIDTH-2:0], 1'b0};
      OP_SHR:   w_res = {bus.in_a[WIDTH-1], bus.in_a[WIDTH-1:1]};
      OP_LHI:   w_res = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
      OP_PASSB: w_res = w_b;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Flags are only loaded alongside the result, so they always describe it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; expected values are hand-computed.
module tb_alu;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_if #(.WIDTH(16), .IMM_W(8)) bus ();

  alu #(.WIDTH(16), .IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] im, input logic sel, input logic [3:0] op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.imm      = im;
    bus.imm_sel  = sel;
    bus.alu_op   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] res, input logic z,
                           input logic o, input logic ov);
    check({tag, ".result"},    bus.result, res);
    check({tag, ".zero"},      {15'd0, bus.zero}, {15'd0, z});
    check({tag, ".ovf"},       {15'd0, bus.ovf}, {15'd0, o});
    check({tag, ".out_valid"}, {15'd0, bus.out_valid}, {15'd0, ov});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;

    // Reset with a live operation presented: it must be discarded.
    apply(1'b1, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd0);
    apply(1'b1, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd0);
    check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0);

    reset = 1'b0;
    apply(1'b0, 16'h1234, 16'h5678, 8'h9A, 1'b0, 4'd0);
    check_all("idle_after_reset", 16'h0000, 1'b1, 1'b0, 1'b0);

    apply(1'b1, 16'h0000, 16'hDEAD, 8'h04, 1'b1, 4'd0);
    check_all("adi", 16'h0004, 1'b0, 1'b0, 1'b1);

    apply(1'b1, 16'h0100, 16'h0000, 8'hFC, 1'b1, 4'd0);
    check_all("neg_imm", 16'h00FC, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h0004, 16'h00FC, 8'hFC, 1'b0, 4'd0);
    check_all("add_reg", 16'h0100, 1'b0, 1'b0, 1'b1);

    apply(1'b1, 16'hFFFF, 16'h1111, 8'h03, 1'b0, 4'd8);
    check_all("lhi_03", 16'h0300, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'hFFFF, 16'h1111, 8'h00, 1'b0, 4'd8);
    check_all("lhi_00", 16'h0000, 1'b1, 1'b0, 1'b1);

    apply(1'b1, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd0);
    check_all("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 16'h8000, 16'h0001, 8'h00, 1'b0, 4'd1);
    check_all("sub_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 16'h0005, 16'h0005, 8'h00, 1'b0, 4'd1);
    check_all("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 16'hFFFF, 16'h0000, 8'hFF, 1'b1, 4'd0);
    check_all("add_neg_neg", 16'hFFFE, 1'b0, 1'b0, 1'b1);

    apply(1'b1, 16'hF0F0, 16'h0FF0, 8'h00, 1'b0, 4'd2);
    check_all("and", 16'h00F0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'hF0F0, 16'h0FF0, 8'h00, 1'b0, 4'd3);
    check_all("orr", 16'hFFF0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h1234, 16'h0FF0, 8'h80, 1'b1, 4'd9);
    check_all("passb_imm", 16'hFF80, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h1234, 16'h0FF0, 8'h80, 1'b0, 4'd9);
    check_all("passb_reg", 16'h0FF0, 1'b0, 1'b0, 1'b1);

    apply(1'b1, 16'h8001, 16'h0000, 8'h00, 1'b0, 4'd6);
    check_all("shl", 16'h0002, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h8001, 16'h0000, 8'h00, 1'b0, 4'd7);
    check_all("shr", 16'hC000, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h8001, 16'h0000, 8'h00, 1'b0, 4'd4);
    check_all("not", 16'h7FFE, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h8001, 16'h0000, 8'h00, 1'b0, 4'd5);
    check_all("tcp", 16'h7FFF, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 16'h8001, 16'h0001, 8'h00, 1'b0, 4'd12);
    check_all("reserved", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Hold: outputs freeze while in_valid is low, whatever the operands do.
    apply(1'b1, 16'h00FF, 16'h0001, 8'h00, 1'b0, 4'd0);
    check_all("hold_setup", 16'h0100, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 4'd1);
    check_all("hold1", 16'h0100, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 16'h7FFF, 16'h0001, 8'hFF, 1'b1, 4'd0);
    check_all("hold2", 16'h0100, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 16'hFFFF, 16'hFFFF, 8'h12, 1'b0, 4'd12);
    check_all("hold3", 16'h0100, 1'b0, 1'b0, 1'b0);

    reset = 1'b1;
    apply(1'b1, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd0);
    check_all("reset_over_valid", 16'h0000, 1'b1, 1'b0, 1'b0);

    reset = 1'b0;
    apply(1'b1, 16'h0003, 16'h0004, 8'h00, 1'b0, 4'd0);
    check_all("first_after_reset", 16'h0007, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
